// File: rtl/sdram_host_pkg.sv
// rtl/sdram_host_pkg.sv - shared defaults and FSM encoding for the SDRAM host-side line reader
package sdram_host_pkg;
  localparam int ADDR_W_DEF     = 24;
  localparam int DATA_W_DEF     = 16;
  localparam int LEN_W_DEF      = 16;
  localparam int FIFO_DEPTH_DEF = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT_SPACE,
    ST_DRAIN,
    ST_ABORT
  } state_t;
endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with registered count, flush, and zeroed head when empty
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  input  logic                     flush,
  output logic [DATA_W-1:0]        head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr, rd_ptr;
  logic              do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  // Head reads as zero while empty so the stream data port has a defined reset value.
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end
endmodule

// File: rtl/sdram_line_reader.sv
// rtl/sdram_line_reader.sv - fetches LEN consecutive SDRAM words via sdram_cntl host port
// and streams them out through a buffering FIFO.
module sdram_line_reader
  import sdram_host_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int LEN_W      = LEN_W_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [LEN_W-1:0]  len_i,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              line_done_o,
  output logic              rd_o,
  output logic              wr_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [DATA_W-1:0] rd_data_i,
  input  logic              cntl_done_i,
  input  logic              rd_pend_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_valid_o,
  input  logic              dout_ready_i
);
  localparam int            CW        = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LAST_SLOT = CW'(FIFO_DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr, addr_n;
  logic [LEN_W-1:0]  remaining, remaining_n;
  logic              line_done, line_done_n;
  logic              push, pop, flush, full, empty;
  logic [CW-1:0]     count;
  logic              unused_rd_pend;

  assign unused_rd_pend = rd_pend_i;

  sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .push      (push),
    .push_data (rd_data_i),
    .pop       (pop),
    .flush     (flush),
    .head      (dout_o),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign dout_valid_o = !empty;
  assign pop          = dout_valid_o && dout_ready_i;
  assign rd_o         = (state == ST_REQ) || (state == ST_ABORT);
  assign wr_o         = 1'b0;
  assign addr_o       = addr;
  assign busy_o       = (state != ST_IDLE);
  assign line_done_o  = line_done;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state     <= ST_IDLE;
      addr      <= '0;
      remaining <= '0;
      line_done <= 1'b0;
    end else begin
      state     <= state_n;
      addr      <= addr_n;
      remaining <= remaining_n;
      line_done <= line_done_n;
    end
  end

  always_comb begin
    state_n     = state;
    addr_n      = addr;
    remaining_n = remaining;
    line_done_n = 1'b0;
    push        = 1'b0;
    flush       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            addr_n      = base_addr_i;
            remaining_n = len_i;
            state_n     = ST_REQ;
          end else begin
            line_done_n = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (abort_i) begin
          flush   = 1'b1;
          state_n = cntl_done_i ? ST_IDLE : ST_ABORT;
        end else if (cntl_done_i) begin
          push        = 1'b1;
          addr_n      = addr + 1'b1;
          remaining_n = remaining - 1'b1;
          // Space check uses the registered count: a same-cycle pop does not free a slot.
          if (remaining == LEN_W'(1))   state_n = ST_DRAIN;
          else if (count == LAST_SLOT)  state_n = ST_WAIT_SPACE;
        end
      end
      ST_WAIT_SPACE: begin
        if (abort_i) begin
          flush   = 1'b1;
          state_n = ST_IDLE;
        end else if (count <= LAST_SLOT) begin
          state_n = ST_REQ;
        end
      end
      ST_DRAIN: begin
        if (abort_i) begin
          flush   = 1'b1;
          state_n = ST_IDLE;
        end else if (pop && count == CW'(1)) begin
          line_done_n = 1'b1;
          state_n     = ST_IDLE;
        end
      end
      ST_ABORT: begin
        // Keep the outstanding read presented until the controller completes it; its word is dropped.
        flush = 1'b1;
        if (cntl_done_i) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end
endmodule

// File: tb/tb_sdram_line_reader.sv
// tb/tb_sdram_line_reader.sv - directed bench for sdram_line_reader with a behavioural host controller
module tb_sdram_line_reader;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, ready;
  logic [23:0] base_addr;
  logic [15:0] len_in;
  logic        busy, line_done, rd, wr;
  logic [23:0] addr;
  logic [15:0] rd_data, dout;
  logic        cntl_done, rd_pend, dout_valid;

  int n_cmp = 0;
  int n_err = 0;
  int ld_cnt = 0;
  logic [15:0] got [$];
  logic [23:0] rlog [$];
  int g0, l0, ld0, nb;

  always #5 clk = ~clk;

  sdram_line_reader dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .start_i      (start),
    .base_addr_i  (base_addr),
    .len_i        (len_in),
    .abort_i      (abort),
    .busy_o       (busy),
    .line_done_o  (line_done),
    .rd_o         (rd),
    .wr_o         (wr),
    .addr_o       (addr),
    .rd_data_i    (rd_data),
    .cntl_done_i  (cntl_done),
    .rd_pend_i    (rd_pend),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (ready)
  );

  // Controller model: completes each read 2 negedges after rd seen, memory holds mem[a]=a[15:0].
  initial begin
    int cnt;
    cnt = 0;
    cntl_done = 1'b0;
    rd_data = '0;
    rd_pend = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        cntl_done = 1'b0;
        cnt = 0;
      end else if (cntl_done) begin
        cntl_done = 1'b0;
        cnt = 0;
      end else if (rd) begin
        cnt++;
        if (cnt == 2) begin
          cntl_done = 1'b1;
          rd_data = addr[15:0];
          rlog.push_back(addr);
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
      rd_pend = rd;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && dout_valid && ready) got.push_back(dout);
      if (line_done) ld_cnt++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic mark();
    g0 = got.size();
    l0 = rlog.size();
    ld0 = ld_cnt;
  endtask

  task automatic start_run(input logic [23:0] b, input logic [15:0] n);
    base_addr = b;
    len_in = n;
    start = 1'b1;
    wait_cycles(1);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int limit);
    for (int i = 0; i < limit && busy; i++) wait_cycles(1);
    chk({tag, "_idle_timeout"}, busy, 0);
    wait_cycles(2);
  endtask

  task automatic check_words(input string tag, input logic [23:0] b, input int n);
    chk({tag, "_nwords"}, got.size() - g0, n);
    chk({tag, "_nreads"}, rlog.size() - l0, n);
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d", tag, i),
          (g0 + i < got.size()) ? 32'(got[g0+i]) : 32'hDEAD_BEEF, 32'(16'(b + 24'(i))));
      chk($sformatf("%s_a%0d", tag, i),
          (l0 + i < rlog.size()) ? 32'(rlog[l0+i]) : 32'hDEAD_BEEF, 32'(24'(b + 24'(i))));
    end
    chk({tag, "_line_done"}, ld_cnt - ld0, 1);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    ready = 1'b0;
    base_addr = '0;
    len_in = '0;
    wait_cycles(2);
    chk("rst_rd", rd, 0);
    chk("rst_wr", wr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_line_done", line_done, 0);
    chk("rst_valid", dout_valid, 0);
    chk("rst_dout", dout, 0);
    rst_n = 1'b1;
    wait_cycles(2);

    // 1: plain run
    mark();
    ready = 1'b1;
    start_run(24'h000100, 16'd8);
    chk("t1_rd_latency", rd, 1);
    chk("t1_addr_first", addr, 24'h000100);
    chk("t1_busy", busy, 1);
    wait_idle("t1", 500);
    check_words("t1", 24'h000100, 8);

    // 2: address wrap
    mark();
    start_run(24'hFFFFFE, 16'd4);
    wait_idle("t2", 500);
    check_words("t2", 24'hFFFFFE, 4);

    // 3: consumer stall fills the buffer exactly
    mark();
    ready = 1'b0;
    start_run(24'h000200, 16'd40);
    wait_cycles(200);
    chk("t3_stall_nwords", got.size() - g0, 0);
    chk("t3_stall_nreads", rlog.size() - l0, 16);
    chk("t3_stall_rd", rd, 0);
    chk("t3_stall_valid", dout_valid, 1);
    chk("t3_stall_head", dout, 16'h0200);
    chk("t3_stall_busy", busy, 1);
    ready = 1'b1;
    wait_idle("t3", 2000);
    check_words("t3", 24'h000200, 40);

    // 4: abort with a read outstanding
    mark();
    start_run(24'h000300, 16'd20);
    for (int i = 0; i < 300 && !((rlog.size() - l0 >= 3) && cntl_done); i++) wait_cycles(1);
    chk("t4_reach_timeout", rlog.size() - l0, 3);
    wait_cycles(1);
    nb = rlog.size() - l0;
    abort = 1'b1;
    wait_cycles(1);
    abort = 1'b0;
    chk("t4_rd_held", rd, 1);
    chk("t4_addr_held", addr, 24'h000303);
    chk("t4_busy", busy, 1);
    chk("t4_flushed", dout_valid, 0);
    wait_cycles(20);
    chk("t4_nreads", rlog.size() - l0, nb + 1);
    chk("t4_last_addr", (rlog.size() > 0) ? 32'(rlog[rlog.size()-1]) : 32'hDEAD_BEEF, 24'h000303);
    chk("t4_rd_off", rd, 0);
    chk("t4_idle", busy, 0);
    chk("t4_valid", dout_valid, 0);
    chk("t4_no_line_done", ld_cnt - ld0, 0);
    mark();
    start_run(24'h000400, 16'd3);
    wait_idle("t4b", 500);
    check_words("t4b", 24'h000400, 3);

    // 5: zero length and start while busy
    mark();
    start_run(24'h000800, 16'd0);
    chk("t5_zero_line_done", line_done, 1);
    chk("t5_zero_busy", busy, 0);
    chk("t5_zero_rd", rd, 0);
    wait_cycles(1);
    chk("t5_zero_pulse_end", line_done, 0);
    chk("t5_zero_nreads", rlog.size() - l0, 0);
    mark();
    start_run(24'h000500, 16'd5);
    wait_cycles(3);
    start_run(24'h000900, 16'd2);
    wait_idle("t5", 500);
    check_words("t5", 24'h000500, 5);

    // 6: reset in the middle of a read
    start_run(24'h000600, 16'd10);
    wait_cycles(4);
    chk("t6_pre_rd", rd, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_rd", rd, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_addr", addr, 0);
    chk("t6_rst_valid", dout_valid, 0);
    chk("t6_rst_dout", dout, 0);
    wait_cycles(1);
    rst_n = 1'b1;
    wait_cycles(1);
    mark();
    start_run(24'h000700, 16'd2);
    wait_idle("t6", 500);
    check_words("t6", 24'h000700, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
